// File: rtl/osd_spi_arbiter_if.sv
// Requester/OSD-port bundle for osd_spi_arbiter.
// master: the requester side (drives req/cmd/len/data, observes handshakes and the SPI pins).
// slave:  the arbiter side.
interface osd_spi_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [8:0] len_a;
    logic [8:0] len_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       data_ack_a;
    logic       data_ack_b;
    logic       grant_a;
    logic       grant_b;
    logic       done_a;
    logic       done_b;
    logic       busy;
    logic       SPI_SCK;
    logic       SPI_SS3;
    logic       SPI_DI;

    modport master (
        output req_a, req_b, cmd_a, cmd_b, len_a, len_b, data_a, data_b,
        input  data_ack_a, data_ack_b, grant_a, grant_b, done_a, done_b, busy,
        input  SPI_SCK, SPI_SS3, SPI_DI
    );

    modport slave (
        input  req_a, req_b, cmd_a, cmd_b, len_a, len_b, data_a, data_b,
        output data_ack_a, data_ack_b, grant_a, grant_b, done_a, done_b, busy,
        output SPI_SCK, SPI_SS3, SPI_DI
    );
endinterface

// File: rtl/osd_spi_arbiter.sv
// Two-port arbiter and serializer for the OSD command port (clk_pix domain).
// Sends one command byte plus up to 256 payload bytes, MSB first, on SPI_SCK/SPI_SS3/SPI_DI.
// Optional macro OSD_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed A-over-B priority.
//
// state    | meaning
// IDLE     | SS3 high, waiting for any request
// SEL      | first SS3-low cycle (T0); winner granted, command loaded
// SHIFT    | clocking bits out; payload bytes fetched on byte boundaries
// LEAD_OUT | SCK low for one half-period before SS3 rises
// GAP      | SS3 held high, requests ignored
module osd_spi_arbiter #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input logic              clk_pix,
    input logic              rst_n,
    osd_spi_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SEL, SHIFT, LEAD_OUT, GAP} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES);

    state_t     state;
    logic [7:0] div_cnt;
    logic [7:0] gap_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [8:0] bytes_left;
    logic       owner_b;
    logic       sck, ss3, di;
    logic       grant_a, grant_b, ack_a, ack_b, done_a, done_b, busy;

    logic       pick_b;
    logic [7:0] win_cmd;
    logic [8:0] win_len;
    logic [7:0] cur_data;

`ifdef OSD_ARB_ROUND_ROBIN_EN
    logic       last_winner_b;
`endif

    // Winner selection and the operands it brings along; len is clamped to 256 bytes.
    always_comb begin
`ifdef OSD_ARB_ROUND_ROBIN_EN
        pick_b = bus.req_b && (!bus.req_a || !last_winner_b);
`else
        pick_b = bus.req_b && !bus.req_a;
`endif
        win_cmd  = pick_b ? bus.cmd_b : bus.cmd_a;
        win_len  = pick_b ? bus.len_b : bus.len_a;
        if (win_len > 9'd256)
            win_len = 9'd256;
        cur_data = owner_b ? bus.data_b : bus.data_a;
    end

    // Sequencer: arbitration, bit clocking, payload fetch, lead-out and inter-transaction gap.
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            bytes_left <= '0;
            owner_b    <= 1'b0;
            sck        <= 1'b0;
            ss3        <= 1'b1;
            di         <= 1'b0;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            done_a     <= 1'b0;
            done_b     <= 1'b0;
            busy       <= 1'b0;
`ifdef OSD_ARB_ROUND_ROBIN_EN
            last_winner_b <= 1'b1;
`endif
        end else begin
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        state      <= SEL;
                        busy       <= 1'b1;
                        ss3        <= 1'b0;
                        owner_b    <= pick_b;
                        grant_a    <= !pick_b;
                        grant_b    <= pick_b;
                        shift_reg  <= win_cmd;
                        di         <= win_cmd[7];
                        bytes_left <= win_len;
                        bit_cnt    <= '0;
                        div_cnt    <= DIV_RELOAD;
                    end
                end
                // SEL already counts toward the first half-period so bit 0 rises at T0+CLK_DIV.
                SEL, SHIFT: begin
                    if (state == SEL)
                        state <= SHIFT;
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_RELOAD;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt   <= bit_cnt + 3'd1;
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                di        <= shift_reg[6];
                            end else if (bytes_left != 9'd0) begin
                                bit_cnt    <= '0;
                                shift_reg  <= cur_data;
                                di         <= cur_data[7];
                                bytes_left <= bytes_left - 9'd1;
                                ack_a      <= !owner_b;
                                ack_b      <= owner_b;
                            end else begin
                                state <= LEAD_OUT;
                                di    <= 1'b0;
                            end
                        end
                    end
                end
                LEAD_OUT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        state   <= GAP;
                        ss3     <= 1'b1;
                        done_a  <= !owner_b;
                        done_b  <= owner_b;
                        grant_a <= 1'b0;
                        grant_b <= 1'b0;
                        gap_cnt <= GAP_LOAD;
`ifdef OSD_ARB_ROUND_ROBIN_EN
                        last_winner_b <= !last_winner_b;
`endif
                    end
                end
                // Extra cycle on top of GAP_CYCLES keeps SS3 high >= GAP_CYCLES+2 including IDLE.
                GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SPI_SCK    = sck;
    assign bus.SPI_SS3    = ss3;
    assign bus.SPI_DI     = di;
    assign bus.grant_a    = grant_a;
    assign bus.grant_b    = grant_b;
    assign bus.data_ack_a = ack_a;
    assign bus.data_ack_b = ack_b;
    assign bus.done_a     = done_a;
    assign bus.done_b     = done_b;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_osd_spi_arbiter.sv
// Bench for osd_spi_arbiter (CLK_DIV=2, GAP_CYCLES=4). An SPI receiver model decodes bytes on
// SCK rising edges and checks them against a queue of expected bytes pushed when stimulus is set.
module tb_osd_spi_arbiter;

    logic clk_pix = 1'b0;
    logic rst_n;

    always #5 clk_pix = ~clk_pix;

    osd_spi_arbiter_if bus ();

    osd_spi_arbiter #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    bit         order_q[$];
    int nbits = 0, low_cnt = 0, high_cnt = 0, rises = 0;
    int last_low = 0, last_rises = 0, last_gap = 0;
    int ack_a_cnt = 0, ack_b_cnt = 0, done_a_cnt = 0, done_b_cnt = 0;
    logic prev_sck = 1'b0, prev_ss3 = 1'b1;
    logic [7:0] rx = 8'h00;
`ifdef OSD_ARB_ROUND_ROBIN_EN
    bit model_last_b = 1'b1;
`endif

    // SPI receiver model plus pulse counters, sampled on the falling clk_pix edge.
    task automatic mon_step();
        logic [7:0] e;
        if (bus.SPI_SS3 === 1'b0) begin
            if (prev_ss3 === 1'b1) begin
                order_q.push_back(bus.grant_b);
                last_gap = high_cnt;
                low_cnt  = 0;
                rises    = 0;
                nbits    = 0;
            end
            low_cnt++;
            if (bus.SPI_SCK === 1'b1 && prev_sck === 1'b0) begin
                rises++;
                rx = {rx[6:0], bus.SPI_DI};
                nbits++;
                if (nbits % 8 == 0) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL spi_byte: got %02h, required no byte (none expected)", rx);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx !== e) begin
                            n_fail++;
                            $display("FAIL spi_byte: got %02h, required %02h", rx, e);
                        end
                    end
                end
            end
        end else begin
            if (prev_ss3 === 1'b0) begin
                last_low   = low_cnt;
                last_rises = rises;
                high_cnt   = 0;
            end
            high_cnt++;
        end
        if (bus.data_ack_a === 1'b1) ack_a_cnt++;
        if (bus.data_ack_b === 1'b1) ack_b_cnt++;
        if (bus.done_a === 1'b1) done_a_cnt++;
        if (bus.done_b === 1'b1) done_b_cnt++;
        prev_sck = bus.SPI_SCK;
        prev_ss3 = bus.SPI_SS3;
    endtask

    // One clock: monitor, then requester response (next payload byte after each ack).
    task automatic cycle();
        @(negedge clk_pix);
        mon_step();
        if (bus.data_ack_a === 1'b1) bus.data_a = bus.data_a + 8'd1;
        if (bus.data_ack_b === 1'b1) bus.data_b = bus.data_b + 8'd1;
`ifdef OSD_ARB_ROUND_ROBIN_EN
        if (bus.done_a === 1'b1 || bus.done_b === 1'b1) model_last_b = ~model_last_b;
`endif
    endtask

    task automatic push_txn(input logic [7:0] cmd, input int len, input logic [7:0] d0);
        int n;
        n = (len > 256) ? 256 : len;
        exp_q.push_back(cmd);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(int'(d0) + i));
    endtask

    // Runs until n done pulses are seen (dropping each req at its done) or the budget expires.
    task automatic drive_until(input int n, input int budget, input string name);
        int got = 0;
        int k   = 0;
        while (got < n && k < budget) begin
            cycle();
            k++;
            if (bus.done_a === 1'b1) begin bus.req_a = 1'b0; got++; end
            if (bus.done_b === 1'b1) begin bus.req_b = 1'b0; got++; end
        end
        n_tests++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d done pulses, required %0d", name, got, n);
        end
        repeat (8) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        n_tests++; if (bus.SPI_SS3 !== 1'b1) begin n_fail++; $display("FAIL reset_ss3: got %b, required 1", bus.SPI_SS3); end
        n_tests++; if (bus.SPI_SCK !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b, required 0", bus.SPI_SCK); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        n_tests++; if ({bus.grant_a, bus.grant_b} !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b, required 00", {bus.grant_a, bus.grant_b}); end
        n_tests++; if (bus.SPI_DI !== 1'b0) begin n_fail++; $display("FAIL reset_di: got %b, required 0", bus.SPI_DI); end
    endtask

    task automatic test_enable_zero_len();
        int a0, d0, o0;
        a0 = ack_a_cnt; d0 = done_a_cnt; o0 = order_q.size();
        bus.cmd_a = 8'h41; bus.len_a = 9'd0; bus.data_a = 8'hEE;
        push_txn(8'h41, 0, 8'hEE);
        bus.req_a = 1'b1;
        drive_until(1, 300, "enable");
        n_tests++; if (last_low != 34) begin n_fail++; $display("FAIL enable_ss3_low: got %0d, required 34", last_low); end
        n_tests++; if (last_rises != 8) begin n_fail++; $display("FAIL enable_sck_pulses: got %0d, required 8", last_rises); end
        n_tests++; if (ack_a_cnt - a0 != 0) begin n_fail++; $display("FAIL enable_acks: got %0d, required 0", ack_a_cnt - a0); end
        n_tests++; if (done_a_cnt - d0 != 1) begin n_fail++; $display("FAIL enable_done: got %0d, required 1", done_a_cnt - d0); end
        n_tests++; if (order_q.size() != o0 + 1 || order_q[o0] !== 1'b0) begin n_fail++; $display("FAIL enable_grant_owner: got size %0d, required A grant", order_q.size()); end
    endtask

    task automatic test_line_write_b();
        int a0, d0;
        a0 = ack_b_cnt; d0 = done_b_cnt;
        bus.cmd_b = 8'h23; bus.len_b = 9'd256; bus.data_b = 8'h00;
        push_txn(8'h23, 256, 8'h00);
        bus.req_b = 1'b1;
        drive_until(1, 9000, "line_b");
        n_tests++; if (ack_b_cnt - a0 != 256) begin n_fail++; $display("FAIL line_b_acks: got %0d, required 256", ack_b_cnt - a0); end
        n_tests++; if (last_rises != 2056) begin n_fail++; $display("FAIL line_b_bits: got %0d, required 2056", last_rises); end
        n_tests++; if (last_low != 8226) begin n_fail++; $display("FAIL line_b_ss3_low: got %0d, required 8226", last_low); end
        n_tests++; if (done_b_cnt - d0 != 1) begin n_fail++; $display("FAIL line_b_done: got %0d, required 1", done_b_cnt - d0); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL line_b_leftover: got %0d bytes, required 0", exp_q.size()); end
    endtask

    task automatic test_simultaneous(input int rep);
        int o0, a0, b0;
        bit first_b;
`ifdef OSD_ARB_ROUND_ROBIN_EN
        first_b = ~model_last_b;
`else
        first_b = 1'b0;
`endif
        o0 = order_q.size(); a0 = ack_a_cnt; b0 = ack_b_cnt;
        bus.cmd_a = 8'h40; bus.len_a = 9'd1; bus.data_a = 8'hA0;
        bus.cmd_b = 8'h41; bus.len_b = 9'd1; bus.data_b = 8'hB0;
        if (first_b) begin
            push_txn(8'h41, 1, 8'hB0); push_txn(8'h40, 1, 8'hA0);
        end else begin
            push_txn(8'h40, 1, 8'hA0); push_txn(8'h41, 1, 8'hB0);
        end
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        drive_until(2, 400, "pair");
        n_tests++;
        if (order_q.size() != o0 + 2) begin
            n_fail++; $display("FAIL pair%0d_count: got %0d, required %0d", rep, order_q.size() - o0, 2);
        end else if (order_q[o0] !== first_b || order_q[o0 + 1] !== ~first_b) begin
            n_fail++; $display("FAIL pair%0d_order: got %b%b, required %b%b (1=B)", rep, order_q[o0], order_q[o0 + 1], first_b, ~first_b);
        end
        n_tests++; if (last_gap < 6) begin n_fail++; $display("FAIL pair%0d_gap: got %0d, required >=6", rep, last_gap); end
        n_tests++; if (ack_a_cnt - a0 != 1 || ack_b_cnt - b0 != 1) begin n_fail++; $display("FAIL pair%0d_acks: got %0d/%0d, required 1/1", rep, ack_a_cnt - a0, ack_b_cnt - b0); end
    endtask

    task automatic test_clamp();
        int a0;
        a0 = ack_a_cnt;
        bus.cmd_a = 8'h21; bus.len_a = 9'd300; bus.data_a = 8'h80;
        push_txn(8'h21, 300, 8'h80);
        bus.req_a = 1'b1;
        drive_until(1, 9000, "clamp");
        n_tests++; if (ack_a_cnt - a0 != 256) begin n_fail++; $display("FAIL clamp_acks: got %0d, required 256", ack_a_cnt - a0); end
        n_tests++; if (last_low != 8226) begin n_fail++; $display("FAIL clamp_ss3_low: got %0d, required 8226", last_low); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int a0, d0;
        bus.cmd_a = 8'h22; bus.len_a = 9'd2; bus.data_a = 8'h10;
        push_txn(8'h22, 2, 8'h10);
        bus.req_a = 1'b1;
        while (!(bus.SPI_SS3 === 1'b0 && nbits == 14) && k < 200) begin cycle(); k++; end
        n_tests++; if (k >= 200) begin n_fail++; $display("FAIL rstmid_reach_bit5: got timeout, required bit 5 of payload"); end
        rst_n = 1'b0; bus.req_a = 1'b0;
        cycle();
        n_tests++; if (bus.SPI_SS3 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ss3: got %b, required 1", bus.SPI_SS3); end
        n_tests++; if (bus.SPI_SCK !== 1'b0 || bus.SPI_DI !== 1'b0) begin n_fail++; $display("FAIL rstmid_sck_di: got %b%b, required 00", bus.SPI_SCK, bus.SPI_DI); end
        n_tests++;
        if ({bus.grant_a, bus.grant_b, bus.data_ack_a, bus.data_ack_b, bus.done_a, bus.done_b, bus.busy} !== 7'b0) begin
            n_fail++; $display("FAIL rstmid_flags: got %b, required 0000000",
                {bus.grant_a, bus.grant_b, bus.data_ack_a, bus.data_ack_b, bus.done_a, bus.done_b, bus.busy});
        end
        rst_n = 1'b1;
        exp_q.delete();
`ifdef OSD_ARB_ROUND_ROBIN_EN
        model_last_b = 1'b1;
`endif
        repeat (3) cycle();
        a0 = ack_a_cnt; d0 = done_a_cnt;
        bus.cmd_a = 8'h41; bus.len_a = 9'd1; bus.data_a = 8'h5A;
        push_txn(8'h41, 1, 8'h5A);
        bus.req_a = 1'b1;
        drive_until(1, 400, "post_reset");
        n_tests++; if (last_low != 66) begin n_fail++; $display("FAIL post_reset_ss3_low: got %0d, required 66", last_low); end
        n_tests++; if (ack_a_cnt - a0 != 1 || done_a_cnt - d0 != 1) begin n_fail++; $display("FAIL post_reset_ack_done: got %0d/%0d, required 1/1", ack_a_cnt - a0, done_a_cnt - d0); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
        bus.len_a = 9'd0;  bus.len_b = 9'd0;
        bus.data_a = 8'h00; bus.data_b = 8'h00;
        test_reset();
        test_enable_zero_len();
        test_line_write_b();
        test_simultaneous(1);
        test_simultaneous(2);
        test_clamp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
